// File: rtl/fft_buf_pkg.sv
// Shared constants and types for the FFT result buffer.
// Bank geometry and the drain-side state encoding.
package fft_buf_pkg;

  localparam int DEPTH  = 512;
  localparam int DW     = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EMPTY,
    READY,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/flex_counter.sv
// Enabled up-counter that wraps to zero after rollover_val.
// rollover_flag marks the terminal count combinationally.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  // count register: clear beats enable, terminal count wraps to 0
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) count_out <= '0;
      else count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: rtl/result_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// The address MSB selects the ping-pong bank.
module result_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];

  // storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // read register, holds its value when re is low
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_result_buffer.sv
// Ping-pong store between FFT core and write-back master.
// One bank fills while the other is drained.
module fft_result_buffer
  import fft_buf_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              res_valid,
  input  logic [DW-1:0]     res_data,
  input  logic              res_last,
  output logic              res_ready,
  input  logic              sReEn,
  input  logic [ADDR_W-1:0] sampled_address,
  output logic [DW-1:0]     sampled_data,
  output logic              fft_done,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  logic [1:0]        full;
  logic [1:0]        set_mask;
  logic [1:0]        clr_mask;
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              wr_end;
  logic              accept;
  logic              complete;
  logic              release_bank;
  logic              last_seen;
  logic              last_seen_n;
  logic              rd_end;
  rd_state_t         state;
  rd_state_t         state_n;

  assign res_ready = !full[wr_bank];
  assign accept    = res_valid && res_ready;
  assign complete  = accept && wr_end;
  assign rd_end    = (sampled_address == ADDR_W'(DEPTH - 1));

  flex_counter #(
    .NUM_CNT_BITS(ADDR_W)
  ) u_wr_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (1'b0),
    .count_enable (accept),
    .rollover_val (ADDR_W'(DEPTH - 1)),
    .count_out    (wr_cnt),
    .rollover_flag(wr_end)
  );

  result_ram #(
    .ADDR_BITS(ADDR_W + 1),
    .DATA_BITS(DW)
  ) u_ram (
    .clk  (clk),
    .n_rst(n_rst),
    .we   (accept),
    .waddr({wr_bank, wr_cnt}),
    .wdata(res_data),
    .re   (sReEn),
    .raddr({rd_bank, sampled_address}),
    .rdata(sampled_data)
  );

  // fill and release masks; never the same bit in one cycle
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (complete) set_mask[wr_bank] = 1'b1;
    if (release_bank) clr_mask[rd_bank] = 1'b1;
  end

  // bank ownership: full flags and both bank pointers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
      if (complete) wr_bank <= ~wr_bank;
      if (release_bank) rd_bank <= ~rd_bank;
    end
  end

  // sticky error flags; a new event wins over err_clr
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun <= (overrun && !err_clr)
               || (res_valid && !res_ready);
      frame_err <= (frame_err && !err_clr)
                 || (accept && (res_last != wr_end));
    end
  end

  // drain FSM state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= EMPTY;
      last_seen <= 1'b0;
    end else begin
      state     <= state_n;
      last_seen <= last_seen_n;
    end
  end

  // drain FSM next state and outputs
  always_comb begin
    state_n      = state;
    last_seen_n  = last_seen;
    release_bank = 1'b0;
    fft_done     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (full[rd_bank]) state_n = READY;
      end
      READY: begin
        fft_done = 1'b1;
        if (sReEn) state_n = DRAIN;
      end
      DRAIN: begin
        if (sReEn && rd_end) last_seen_n = 1'b1;
        if (!sReEn && last_seen) begin
          release_bank = 1'b1;
          last_seen_n  = 1'b0;
          state_n      = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_fft_result_buffer.sv
// Directed bench for fft_result_buffer.
// Expected values are hand-derived from the frame patterns.
module tb_fft_result_buffer;

  logic        clk;
  logic        n_rst;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_last;
  logic        res_ready;
  logic        sReEn;
  logic [8:0]  sampled_address;
  logic [15:0] sampled_data;
  logic        fft_done;
  logic        overrun;
  logic        frame_err;
  logic        err_clr;

  int n_chk;
  int n_pass;

  fft_result_buffer dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_last       (res_last),
    .res_ready      (res_ready),
    .sReEn          (sReEn),
    .sampled_address(sampled_address),
    .sampled_data   (sampled_data),
    .fft_done       (fft_done),
    .overrun        (overrun),
    .frame_err      (frame_err),
    .err_clr        (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    res_last = 1'b0;
    sReEn = 1'b0;
    sampled_address = '0;
    err_clr = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic send(input logic [15:0] base,
                      input int lo, input int hi,
                      input int last_idx);
    for (int i = lo; i <= hi; i++) begin
      res_valid = 1'b1;
      res_data = base + 16'(i);
      res_last = (i == last_idx);
      tick();
    end
    res_valid = 1'b0;
    res_last = 1'b0;
  endtask

  task automatic rd_range(input logic [15:0] base,
                          input int lo, input int hi,
                          input int hold);
    logic [15:0] exp;
    for (int a = lo; a <= hi; a++) begin
      sReEn = 1'b1;
      sampled_address = 9'(a);
      tick();
      exp = base + 16'(a);
      check($sformatf("rd%0d", a),
            {16'h0, sampled_data}, {16'h0, exp});
      for (int h = 1; h < hold; h++) tick();
    end
  endtask

  task automatic drain(input logic [15:0] base,
                       input int hold);
    rd_range(base, 0, 511, hold);
    sReEn = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    do_reset();

    check("rst_data", {16'h0, sampled_data}, 0);
    check("rst_done", {31'h0, fft_done}, 0);
    check("rst_ovr", {31'h0, overrun}, 0);
    check("rst_ferr", {31'h0, frame_err}, 0);
    check("rst_rdy", {31'h0, res_ready}, 1);

    // frame of 0..511, then master-cadence drain
    send(16'h0000, 0, 511, 511);
    check("f0_full", {30'h0, dut.full}, 2'b01);
    check("f0_done0", {31'h0, fft_done}, 0);
    check("f0_rdy", {31'h0, res_ready}, 1);
    check("f0_ferr", {31'h0, frame_err}, 0);
    tick();
    check("f0_done1", {31'h0, fft_done}, 1);
    rd_range(16'h0000, 0, 0, 4);
    check("f0_dfall", {31'h0, fft_done}, 0);
    rd_range(16'h0000, 1, 511, 4);
    check("f0_held", {30'h0, dut.full}, 2'b01);
    sReEn = 1'b0;
    tick();
    check("f0_free", {30'h0, dut.full}, 2'b00);
    check("f0_rbank", {31'h0, dut.rd_bank}, 1);
    check("f0_hold", {16'h0, sampled_data}, 16'h01FF);
    repeat (3) tick();
    check("f0_once", {31'h0, dut.rd_bank}, 1);
    check("f0_idle", {31'h0, fft_done}, 0);

    // two frames, overrun, then drain both banks
    do_reset();
    send(16'h2000, 0, 511, 511);
    send(16'h1000, 0, 511, 511);
    check("ff_full", {30'h0, dut.full}, 2'b11);
    check("ff_rdy", {31'h0, res_ready}, 0);
    check("ff_done", {31'h0, fft_done}, 1);
    res_valid = 1'b1;
    res_data = 16'hDEAD;
    res_last = 1'b1;
    tick();
    res_valid = 1'b0;
    res_last = 1'b0;
    check("ovr_set", {31'h0, overrun}, 1);
    check("ovr_ferr", {31'h0, frame_err}, 0);
    drain(16'h2000, 1);
    check("ovr_rdy", {31'h0, res_ready}, 1);
    check("b1_done0", {31'h0, fft_done}, 0);
    tick();
    check("b1_done1", {31'h0, fft_done}, 1);
    drain(16'h1000, 1);
    check("ovr_stky", {31'h0, overrun}, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_clr", {31'h0, overrun}, 0);

    // early res_last on word 100
    send(16'h3000, 0, 150, 100);
    check("fe_set", {31'h0, frame_err}, 1);
    check("fe_nodone", {31'h0, fft_done}, 0);
    check("fe_nofull", {30'h0, dut.full}, 2'b00);
    send(16'h3000, 151, 511, 100);
    tick();
    check("fe_done", {31'h0, fft_done}, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("fe_clr", {31'h0, frame_err}, 0);

    // release bank 0 while bank 1 completes
    rd_range(16'h3000, 0, 511, 1);
    send(16'h4000, 0, 4, 5);
    res_valid = 1'b1;
    res_data = 16'h4005;
    res_last = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("fe_win", {31'h0, frame_err}, 1);
    send(16'h4000, 6, 510, 5);
    sReEn = 1'b0;
    res_valid = 1'b1;
    res_data = 16'h41FF;
    res_last = 1'b1;
    tick();
    res_valid = 1'b0;
    res_last = 1'b0;
    check("sim_full", {30'h0, dut.full}, 2'b10);
    check("sim_rbank", {31'h0, dut.rd_bank}, 1);
    check("sim_rdy", {31'h0, res_ready}, 1);
    check("sim_done0", {31'h0, fft_done}, 0);
    tick();
    check("sim_done1", {31'h0, fft_done}, 1);
    drain(16'h4000, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // asynchronous reset in the middle of a drain
    send(16'h5000, 0, 511, 10);
    tick();
    check("ar_ferr", {31'h0, frame_err}, 1);
    rd_range(16'h5000, 0, 200, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("ar_data", {16'h0, sampled_data}, 0);
    check("ar_done", {31'h0, fft_done}, 0);
    check("ar_ovr", {31'h0, overrun}, 0);
    check("ar_ferr0", {31'h0, frame_err}, 0);
    check("ar_rdy", {31'h0, res_ready}, 1);
    sReEn = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    send(16'h6000, 0, 511, 511);
    check("nf_full", {30'h0, dut.full}, 2'b01);
    tick();
    check("nf_done", {31'h0, fft_done}, 1);
    drain(16'h6000, 1);
    check("nf_free", {30'h0, dut.full}, 2'b00);
    check("nf_ferr", {31'h0, frame_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
